// File: rtl/tl_pkg.sv
// Shared traffic-light types, light encodings and one-hot helpers used by the
// source and pedestrian-request selectors.
package tl_pkg;

  typedef logic [1:0] light_t;

  localparam light_t RED       = 2'b00;
  localparam light_t YELLOW    = 2'b01;
  localparam light_t GREEN     = 2'b10;
  localparam light_t UNDEFINED = 2'b11;

  // Helpers take selects zero-extended to this width, so N_SRC must not exceed it.
  localparam int MAX_SRC   = 32;
  localparam int MAX_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_NONE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_YIELD = 2'd2
  } sw_state_t;

  function automatic logic onehot_valid(input logic [MAX_SRC-1:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_SRC-1:0] v);
    logic [MAX_IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (v[i]) r = MAX_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sel_qualifier.sv
// Debounces a one-hot select: qual is high once sel has been steady for
// STABLE_CYCLES cycles, presenting the registered select and its validity.
module sel_qualifier
  import tl_pkg::*;
#(
  parameter int N_SRC         = 6,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] sel,
  output logic             qual,
  output logic [N_SRC-1:0] qsel,
  output logic             valid
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N_SRC-1:0] sel_q;
  logic [CNT_W-1:0] stab_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      stab_cnt <= '0;
    end else begin
      sel_q <= sel;
      if (sel != sel_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
    end
  end

  assign qual  = (sel == sel_q) && (stab_cnt == CNT_MAX);
  assign qsel  = sel_q;
  assign valid = onehot_valid(MAX_SRC'(sel_q));

endmodule

// File: rtl/light_source_switch.sv
// Selects one of N_SRC light/countdown sources from a debounced one-hot select,
// forcing a YELLOW phase whenever the hand-off would cut a GREEN short.
module light_source_switch
  import tl_pkg::*;
#(
  parameter int N_SRC         = 6,
  parameter int TIME_W        = 5,
  parameter int STABLE_CYCLES = 2,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        sel,
  input  logic [2*N_SRC-1:0]      light_in,
  input  logic [TIME_W*N_SRC-1:0] time_in,
  output light_t                  light,
  output logic [TIME_W-1:0]       light_time,
  output logic [N_SRC-1:0]        active_sel,
  output logic                    switching,
  output logic                    sel_err
);

  localparam int IDX_W  = $clog2(N_SRC);
  localparam int YCNT_W = (YELLOW_CYCLES > 0) ? $clog2(YELLOW_CYCLES + 1) : 1;

  logic             qual;
  logic             qvalid;
  logic [N_SRC-1:0] qsel;
  logic [IDX_W-1:0] q_idx;

  sel_qualifier #(
    .N_SRC         (N_SRC),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_qual (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .qual  (qual),
    .qsel  (qsel),
    .valid (qvalid)
  );

  assign q_idx = IDX_W'(onehot_to_idx(MAX_SRC'(qsel)));

  sw_state_t         state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [IDX_W-1:0]  tgt, tgt_d;
  logic              tgt_ok, tgt_ok_d;
  logic [YCNT_W-1:0] ycnt, ycnt_d;

  light_t            light_d;
  logic [TIME_W-1:0] light_time_d;
  logic [N_SRC-1:0]  active_sel_d;
  logic              switching_d;

  light_t            src_light;
  logic [TIME_W-1:0] src_time;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_NONE;
      idx        <= '0;
      tgt        <= '0;
      tgt_ok     <= 1'b0;
      ycnt       <= '0;
      light      <= UNDEFINED;
      light_time <= '0;
      active_sel <= '0;
      switching  <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      tgt        <= tgt_d;
      tgt_ok     <= tgt_ok_d;
      ycnt       <= ycnt_d;
      light      <= light_d;
      light_time <= light_time_d;
      active_sel <= active_sel_d;
      switching  <= switching_d;
      if (qual) sel_err <= !qvalid;
    end
  end

  // The GREEN test looks at the registered output, i.e. the outgoing source only.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    tgt_d    = tgt;
    tgt_ok_d = tgt_ok;
    ycnt_d   = ycnt;
    unique case (state)
      ST_NONE: begin
        if (qual && qvalid) begin
          state_d = ST_PASS;
          idx_d   = q_idx;
        end
      end
      ST_PASS: begin
        if (qual) begin
          if (!qvalid) begin
            state_d = ST_NONE;
          end else if (q_idx != idx) begin
            if (light == GREEN && YELLOW_CYCLES > 0) begin
              state_d  = ST_YIELD;
              tgt_d    = q_idx;
              tgt_ok_d = 1'b1;
              ycnt_d   = YCNT_W'(YELLOW_CYCLES);
            end else begin
              idx_d = q_idx;
            end
          end
        end
      end
      ST_YIELD: begin
        ycnt_d = ycnt - YCNT_W'(1);
        if (qual) begin
          tgt_ok_d = qvalid;
          if (qvalid) tgt_d = q_idx;
        end
        if (ycnt == YCNT_W'(1)) begin
          if (tgt_ok_d) begin
            state_d = ST_PASS;
            idx_d   = tgt_d;
          end else begin
            state_d = ST_NONE;
          end
        end
      end
      default: state_d = ST_NONE;
    endcase
  end

  always_comb begin
    src_light = UNDEFINED;
    src_time  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (IDX_W'(i) == idx_d) begin
        src_light = light_in[2*i +: 2];
        src_time  = time_in[TIME_W*i +: TIME_W];
      end
    end
  end

  // Outputs are built from the next-state values so they register in step with the FSM.
  always_comb begin
    light_d      = UNDEFINED;
    light_time_d = '0;
    active_sel_d = '0;
    switching_d  = 1'b0;
    unique case (state_d)
      ST_PASS: begin
        light_d      = src_light;
        light_time_d = src_time;
        active_sel_d = N_SRC'(1) << idx_d;
      end
      ST_YIELD: begin
        light_d      = YELLOW;
        light_time_d = TIME_W'(ycnt_d);
        active_sel_d = N_SRC'(1) << idx_d;
        switching_d  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_light_source_switch.sv
// Directed bench for light_source_switch: reset, plain and GREEN hand-offs,
// retarget during YELLOW, invalid selects and select glitches.
module tb_light_source_switch;

  localparam int N_SRC  = 6;
  localparam int TIME_W = 5;

  logic                    clk;
  logic                    rst;
  logic [N_SRC-1:0]        sel;
  logic [2*N_SRC-1:0]      light_in;
  logic [TIME_W*N_SRC-1:0] time_in;
  logic [1:0]              light;
  logic [TIME_W-1:0]       light_time;
  logic [N_SRC-1:0]        active_sel;
  logic                    switching;
  logic                    sel_err;

  int n_tests = 0;
  int n_fail  = 0;

  light_source_switch #(
    .N_SRC         (N_SRC),
    .TIME_W        (TIME_W),
    .STABLE_CYCLES (2),
    .YELLOW_CYCLES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .light_in   (light_in),
    .time_in    (time_in),
    .light      (light),
    .light_time (light_time),
    .active_sel (active_sel),
    .switching  (switching),
    .sel_err    (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] l, input int t,
                           input logic [N_SRC-1:0] a, input logic s);
    check({tag, ".light"}, 32'(light), 32'(l));
    check({tag, ".time"}, 32'(light_time), 32'(t));
    check({tag, ".active"}, 32'(active_sel), 32'(a));
    check({tag, ".switching"}, 32'(switching), 32'(s));
  endtask

  task automatic set_src(input int i, input logic [1:0] l, input int t);
    light_in[2*i +: 2]          = l;
    time_in[TIME_W*i +: TIME_W] = TIME_W'(t);
  endtask

  initial begin
    rst      = 1'b1;
    sel      = 6'b000001;
    light_in = '0;
    time_in  = '0;
    set_src(0, 2'b00, 5);
    set_src(1, 2'b01, 12);
    set_src(2, 2'b10, 17);
    set_src(3, 2'b11, 3);
    set_src(4, 2'b00, 9);
    set_src(5, 2'b10, 20);

    // reset and first qualification of src0
    tick(); tick();
    check_out("rst", 2'b11, 0, 6'b000000, 1'b0);
    check("rst.sel_err", 32'(sel_err), 32'd0);
    rst = 1'b0;
    tick();
    check_out("post_rst1", 2'b11, 0, 6'b000000, 1'b0);
    tick();
    check_out("post_rst2", 2'b11, 0, 6'b000000, 1'b0);
    tick();
    check_out("src0", 2'b00, 5, 6'b000001, 1'b0);
    check("src0.sel_err", 32'(sel_err), 32'd0);

    // non-GREEN hand-off: src0 RED -> src2
    sel = 6'b000100;
    tick(); check_out("ng_hold1", 2'b00, 5, 6'b000001, 1'b0);
    tick(); check_out("ng_hold2", 2'b00, 5, 6'b000001, 1'b0);
    tick(); check_out("ng_src2", 2'b10, 17, 6'b000100, 1'b0);
    set_src(2, 2'b10, 16);
    tick(); check_out("ng_latency", 2'b10, 16, 6'b000100, 1'b0);

    // GREEN hand-off: src2 GREEN -> src4 with a 3-cycle YELLOW
    sel = 6'b010000;
    tick(); check_out("gh_hold1", 2'b10, 16, 6'b000100, 1'b0);
    tick(); check_out("gh_hold2", 2'b10, 16, 6'b000100, 1'b0);
    tick(); check_out("gh_y3", 2'b01, 3, 6'b000100, 1'b1);
    tick(); check_out("gh_y2", 2'b01, 2, 6'b000100, 1'b1);
    tick(); check_out("gh_y1", 2'b01, 1, 6'b000100, 1'b1);
    tick(); check_out("gh_src4", 2'b00, 9, 6'b010000, 1'b0);

    // back to src2 (outgoing RED, so no YELLOW)
    sel = 6'b000100;
    tick(); check_out("back_hold1", 2'b00, 9, 6'b010000, 1'b0);
    tick(); check_out("back_hold2", 2'b00, 9, 6'b010000, 1'b0);
    tick(); check_out("back_src2", 2'b10, 16, 6'b000100, 1'b0);

    // retarget to src5 while YELLOW is running; phase length stays 3
    sel = 6'b010000;
    tick(); check_out("rt_hold1", 2'b10, 16, 6'b000100, 1'b0);
    tick(); check_out("rt_hold2", 2'b10, 16, 6'b000100, 1'b0);
    tick(); check_out("rt_y3", 2'b01, 3, 6'b000100, 1'b1);
    sel = 6'b100000;
    tick(); check_out("rt_y2", 2'b01, 2, 6'b000100, 1'b1);
    tick(); check_out("rt_y1", 2'b01, 1, 6'b000100, 1'b1);
    tick(); check_out("rt_src5", 2'b10, 20, 6'b100000, 1'b0);
    tick(); check_out("rt_src5b", 2'b10, 20, 6'b100000, 1'b0);

    // all-zero select drops to NONE, no YELLOW even though src5 was GREEN
    sel = 6'b000000;
    tick(); check_out("zero_hold1", 2'b10, 20, 6'b100000, 1'b0);
    tick(); check_out("zero_hold2", 2'b10, 20, 6'b100000, 1'b0);
    check("zero_hold2.sel_err", 32'(sel_err), 32'd0);
    tick(); check_out("zero_none", 2'b11, 0, 6'b000000, 1'b0);
    check("zero_none.sel_err", 32'(sel_err), 32'd1);
    tick(); check_out("zero_none2", 2'b11, 0, 6'b000000, 1'b0);

    // multi-hot select keeps NONE and sel_err high
    sel = 6'b001100;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_out("multi_none", 2'b11, 0, 6'b000000, 1'b0);
      check("multi_none.sel_err", 32'(sel_err), 32'd1);
    end

    // recovery to src1
    sel = 6'b000010;
    tick(); check("rec_hold1.sel_err", 32'(sel_err), 32'd1);
    tick(); check_out("rec_hold2", 2'b11, 0, 6'b000000, 1'b0);
    tick(); check_out("rec_src1", 2'b01, 12, 6'b000010, 1'b0);
    check("rec_src1.sel_err", 32'(sel_err), 32'd0);

    // select toggling every cycle never qualifies
    for (int k = 0; k < 10; k++) begin
      sel = (k % 2 == 0) ? 6'b000001 : 6'b000010;
      tick();
      check_out("glitch", 2'b01, 12, 6'b000010, 1'b0);
      check("glitch.sel_err", 32'(sel_err), 32'd0);
    end
    tick(); tick(); tick();
    check_out("glitch_settle", 2'b01, 12, 6'b000010, 1'b0);

    // multi-hot straight from PASS
    sel = 6'b001100;
    tick(); tick();
    check_out("mh_hold", 2'b01, 12, 6'b000010, 1'b0);
    tick();
    check_out("mh_none", 2'b11, 0, 6'b000000, 1'b0);
    check("mh_none.sel_err", 32'(sel_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
